// File: rtl/usbfs_rx_pkt_buf_if.sv
// ---------------------------------------------------------------------------
// usbfs_rx_pkt_buf_if
// Bundles the decoder-facing receive strobes, the handshake result and the
// endpoint-facing valid/ready + random-access read port of the USB full-speed
// OUT/SETUP packet buffer.
//   master : driven by the receive decoder / OUT endpoint side (bench)
//   slave  : the packet buffer itself
// Receive side : i_start, i_pid1, i_byteValid, i_byte, i_end, i_abort,
//                i_toggleClr
// Result       : o_rsltValid, o_rslt (00 silent, 01 ACK, 10 NAK)
// Endpoint     : o_erValid, i_erReady, o_erRdNBytes, i_erRdEn, i_erRdIdx,
//                o_erRdByte
// ---------------------------------------------------------------------------
interface usbfs_rx_pkt_buf_if #(
    parameter int MAX_PKT = 8
);
    localparam int NB_W  = $clog2(MAX_PKT + 1);
    localparam int IDX_W = $clog2(MAX_PKT);

    logic             i_start;
    logic             i_pid1;
    logic             i_byteValid;
    logic [7:0]       i_byte;
    logic             i_end;
    logic             i_abort;
    logic             i_toggleClr;
    logic             o_rsltValid;
    logic [1:0]       o_rslt;
    logic             o_erValid;
    logic             i_erReady;
    logic [NB_W-1:0]  o_erRdNBytes;
    logic             i_erRdEn;
    logic [IDX_W-1:0] i_erRdIdx;
    logic [7:0]       o_erRdByte;

    modport master (
        output i_start, i_pid1, i_byteValid, i_byte, i_end, i_abort,
               i_toggleClr, i_erReady, i_erRdEn, i_erRdIdx,
        input  o_rsltValid, o_rslt, o_erValid, o_erRdNBytes, o_erRdByte
    );

    modport slave (
        input  i_start, i_pid1, i_byteValid, i_byte, i_end, i_abort,
               i_toggleClr, i_erReady, i_erRdEn, i_erRdIdx,
        output o_rsltValid, o_rslt, o_erValid, o_erRdNBytes, o_erRdByte
    );
endinterface

// File: rtl/usbfs_rx_pkt_buf.sv
// ---------------------------------------------------------------------------
// usbfs_rx_pkt_buf
// Host-to-device packet buffer for USB full-speed DATA0/DATA1 payloads.
// Collects payload + CRC16 bytes, checks CRC residual, length and data
// toggle, reports the handshake to send (silent/ACK/NAK) and holds one good
// payload for the OUT endpoint (valid/ready plus registered read port).
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : usbfs_rx_pkt_buf_if.slave (receive strobes, result, endpoint)
// ---------------------------------------------------------------------------
module usbfs_rx_pkt_buf #(
    parameter int MAX_PKT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    usbfs_rx_pkt_buf_if.slave   bus
);
    localparam int CNT_W  = $clog2(MAX_PKT + 3);
    localparam int MEM_N  = MAX_PKT + 2;
    localparam int MEM_AW = $clog2(MEM_N);
    localparam int NB_W   = $clog2(MAX_PKT + 1);

    localparam logic [CNT_W-1:0] CNT_MEM = CNT_W'(MEM_N);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PKT + 3);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(2);
    localparam logic [15:0]      CRC_INIT     = 16'hFFFF;
    localparam logic [15:0]      CRC_RESIDUAL = 16'h800D;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] DROP  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    localparam logic [1:0] RSLT_SILENT = 2'b00;
    localparam logic [1:0] RSLT_ACK    = 2'b01;
    localparam logic [1:0] RSLT_NAK    = 2'b10;

    logic [2:0]       state;
    logic [2:0]       ret_state;   // HOLD/DRAIN to resume after a DROP
    logic [CNT_W-1:0] count;
    logic [15:0]      crc;
    logic             ovf;
    logic             pid;
    logic             toggle;      // expected data toggle
    logic [7:0]       mem [MEM_N];

    // Serial CRC16 over one byte, LSb first as it appears on the wire.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                               input logic [7:0]  b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    logic [2:0] ret_target;
    logic       pkt_bad;
    logic       handshake;
    logic       wr_en;

    // Where an aborted or failed packet goes: a dropped packet resumes the
    // held one, a received one just falls back to IDLE.
    assign ret_target = (state == DROP) ? ret_state : IDLE;
    assign pkt_bad    = (crc != CRC_RESIDUAL) || (count < CNT_MIN) || ovf;
    assign handshake  = bus.i_erReady && bus.o_erValid;
    // Only RECV writes storage, so a held packet survives a DROP intact.
    assign wr_en      = (state == RECV) && bus.i_byteValid && !bus.i_start &&
                        !bus.i_abort && (count < CNT_MEM);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            ret_state        <= IDLE;
            count            <= '0;
            crc              <= CRC_INIT;
            ovf              <= 1'b0;
            pid              <= 1'b0;
            toggle           <= 1'b0;
            bus.o_rsltValid  <= 1'b0;
            bus.o_rslt       <= RSLT_SILENT;
            bus.o_erValid    <= 1'b0;
            bus.o_erRdNBytes <= '0;
        end else begin
            bus.o_rsltValid <= 1'b0;
            bus.o_rslt      <= RSLT_SILENT;

            // A new PID restarts the byte/CRC tracking in every state.
            if (bus.i_start) begin
                count <= '0;
                crc   <= CRC_INIT;
                ovf   <= 1'b0;
                pid   <= bus.i_pid1;
            end

            case (state)
                IDLE: begin
                    if (bus.i_start) state <= RECV;
                end
                RECV, DROP: begin
                    if (bus.i_start) begin
                        state <= state;
                    end else if (bus.i_abort) begin
                        state         <= ret_target;
                        bus.o_erValid <= (ret_target == HOLD);
                    end else if (bus.i_byteValid) begin
                        crc <= crc16_byte(crc, bus.i_byte);
                        if (count != CNT_SAT) count <= count + CNT_W'(1);
                        if (count >= CNT_MEM) ovf <= 1'b1;
                    end else if (bus.i_end) begin
                        bus.o_rsltValid <= 1'b1;
                        if (pkt_bad) begin
                            bus.o_rslt    <= RSLT_SILENT;
                            state         <= ret_target;
                            bus.o_erValid <= (ret_target == HOLD);
                        end else if (state == DROP) begin
                            bus.o_rslt    <= RSLT_NAK;
                            state         <= ret_state;
                            bus.o_erValid <= (ret_state == HOLD);
                        end else if (pid != toggle) begin
                            // Host missed our ACK and resent: ACK, no commit.
                            bus.o_rslt <= RSLT_ACK;
                            state      <= IDLE;
                        end else begin
                            bus.o_rslt       <= RSLT_ACK;
                            toggle           <= ~toggle;
                            bus.o_erRdNBytes <= NB_W'(count - CNT_MIN);
                            state            <= HOLD;
                            bus.o_erValid    <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.i_start) begin
                        // A coincident handshake already transferred
                        // ownership, so resume in DRAIN in that case.
                        state         <= DROP;
                        ret_state     <= handshake ? DRAIN : HOLD;
                        bus.o_erValid <= 1'b0;
                    end else if (handshake) begin
                        state         <= DRAIN;
                        bus.o_erValid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (bus.i_start) begin
                        state     <= DROP;
                        ret_state <= DRAIN;
                    end else if (!bus.i_erRdEn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed last so a clear beats the toggle flip of a commit.
            if (bus.i_toggleClr) toggle <= 1'b0;
        end
    end

    // NOTE: the payload storage has no reset; its contents are only
    // meaningful after a commit, and leaving it out keeps it a plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[MEM_AW'(count)] <= bus.i_byte;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_erRdByte <= 8'h00;
        end else if (bus.i_erRdEn) begin
            bus.o_erRdByte <= mem[MEM_AW'(bus.i_erRdIdx)];
        end
    end
endmodule
